// File: rtl/dbus_march_initiator_pkg.sv
// rtl/dbus_march_initiator_pkg.sv - shared types and helpers for the dbus March initiator
//
// Purpose: FSM state and test phase enums, byte-enable constant, and the
// address / expected-data helpers used by the initiator and its benches.
// Ports: none (package).

package dbus_march_pkg;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  // P1: write D, P2R: read/compare D, P2W: write ~D, P3: read/compare ~D (descending)
  typedef enum logic [1:0] {P1, P2W, P2R, P3} phase_t;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

  function automatic logic [31:0] expected_data(input logic [31:0] pattern,
                                                input logic [31:0] base,
                                                input logic [31:0] idx,
                                                input logic        inv);
    logic [31:0] d;
    d = pattern ^ word_addr(base, idx);
    return inv ? ~d : d;
  endfunction

endpackage

// File: rtl/dbus_march_initiator_if.sv
// rtl/dbus_march_initiator_if.sv - sim data-bus (cyc/gnt/ack) interface
//
// Purpose: groups the request/response signals of the sim data bus.
// Ports (master view): o_cyc, o_adr, o_we, o_be, o_dat out; i_gnt, i_ack, i_rdt in.
// The slave modport is the responder's view of the same wires.

interface dbus_march_initiator_if;
  logic        o_cyc;
  logic [31:0] o_adr;
  logic        o_we;
  logic [3:0]  o_be;
  logic [31:0] o_dat;
  logic        i_gnt;
  logic        i_ack;
  logic [31:0] i_rdt;

  modport master (
    output o_cyc, o_adr, o_we, o_be, o_dat,
    input  i_gnt, i_ack, i_rdt
  );

  modport slave (
    input  o_cyc, o_adr, o_we, o_be, o_dat,
    output i_gnt, i_ack, i_rdt
  );
endinterface

// File: rtl/dbus_march_initiator.sv
// rtl/dbus_march_initiator.sv - March-style pattern test initiator on the sim data bus
//
// Purpose: on start, writes D(i), then reads D(i)/writes ~D(i) ascending, then
// reads ~D(i) descending over NUM_WORDS words at BASE_ADDR; reports pass/fail,
// mismatch count and the first failing address/data.
// Ports: clk, rst (sync, active-high); start in; busy, done, pass, bus_err,
// err_count[15:0], first_err_addr[31:0], first_err_data[31:0] out;
// bus (dbus_march_initiator_if.master).

module dbus_march_initiator
  import dbus_march_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          NUM_WORDS = 4,
  parameter logic [31:0] PATTERN   = 32'hA5A5_A5A5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          bus_err,
  output logic [15:0]                   err_count,
  output logic [31:0]                   first_err_addr,
  output logic [31:0]                   first_err_data,
  dbus_march_initiator_if.master        bus
);

  localparam logic [31:0] LAST_IDX = 32'(NUM_WORDS - 1);

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [31:0] idx, idx_n;
  logic        rd_access;
  logic        accept_start;
  logic [31:0] cur_addr;
  logic [31:0] exp_data;

  assign rd_access    = (phase == P2R) || (phase == P3);
  assign cur_addr     = word_addr(BASE_ADDR, idx);
  // ~D is both the P2W write data and the P3 compare value.
  assign exp_data     = expected_data(PATTERN, BASE_ADDR, idx,
                                      (phase == P2W) || (phase == P3));
  assign accept_start = start && ((state == S_IDLE) || (state == S_DONE));

  assign busy = (state == S_REQ) || (state == S_RESP);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == 16'd0) && !bus_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      phase <= P1;
      idx   <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    idx_n     = idx;
    bus.o_cyc = 1'b0;
    bus.o_adr = '0;
    bus.o_we  = 1'b0;
    bus.o_be  = '0;
    bus.o_dat = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_REQ;
          phase_n = P1;
          idx_n   = '0;
        end
      end
      S_REQ: begin
        bus.o_cyc = 1'b1;
        bus.o_adr = cur_addr;
        bus.o_we  = !rd_access;
        bus.o_be  = BE_ALL;
        bus.o_dat = rd_access ? 32'h0 : exp_data;
        if (bus.i_gnt) state_n = S_RESP;
      end
      S_RESP: begin
        if (!bus.i_ack) begin
          state_n = S_DONE;
        end else begin
          state_n = S_REQ;
          case (phase)
            P1: begin
              if (idx == LAST_IDX) begin
                phase_n = P2R;
                idx_n   = '0;
              end else begin
                idx_n = idx + 32'd1;
              end
            end
            P2R: phase_n = P2W;
            P2W: begin
              if (idx == LAST_IDX) begin
                phase_n = P3;
              end else begin
                phase_n = P2R;
                idx_n   = idx + 32'd1;
              end
            end
            P3: begin
              // i = 0 is the final access; stop here rather than wrapping.
              if (idx == 32'd0) state_n = S_DONE;
              else              idx_n   = idx - 32'd1;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (accept_start) begin
      bus_err        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (state == S_RESP) begin
      if (!bus.i_ack) begin
        bus_err <= 1'b1;
      end else if (rd_access && (bus.i_rdt != exp_data)) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0) begin
          first_err_addr <= cur_addr;
          first_err_data <= bus.i_rdt;
        end
      end
    end
  end

endmodule

// File: doc/dbus_march_initiator.md
# dbus_march_initiator

Bus initiator for the sim data-bus protocol (cyc/gnt/ack, word-wide, byte enables), built to run on the same port the CPU drives into the sim memory/peripheral responder. On `start` it runs a three-phase March-style pattern test over a word range and compares read data against expected values. It reports pass/fail, an error count and the first failing address/data. Uses: memory self-check before firmware launch, and golden traffic for responder fault-injection campaigns.

## Interface
- `BASE_ADDR`, 32'h0000_0100: byte address of word 0; must be 4-byte aligned.
- `NUM_WORDS`, 4: words tested; must be ≥1.
- `PATTERN`, 32'hA5A5_A5A5: seed for expected data.

Ports:
- Clock and reset: `clk`, `rst`. Reset is synchronous, active-high; clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  one-cycle request to begin a test
- `busy`  out  1  test in progress
- `done`  out  1  test finished; held until next accepted `start`
- `pass`  out  1  valid while `done`; 1 = no mismatch and no bus error
- `bus_err`  out  1  ack missing in response cycle
- `err_count`  out  16  data mismatches; saturates at 16'hFFFF
- `first_err_addr`  out  32  address of first mismatch
- `first_err_data`  out  32  read data of first mismatch
- `o_cyc`  out  1  request valid
- `o_adr`  out  32  byte address
- `o_we`  out  1  1 = write
- `o_be`  out  4  4'hF while `o_cyc`, else 4'h0
- `o_dat`  out  32  write data
- `i_gnt`  in  1  request accepted this cycle (may be combinational from `o_cyc`)
- `i_ack`  in  1  response valid
- `i_rdt`  in  32  read data, valid with `i_ack`

## Operation
- Expected data: D(i) = `PATTERN` ^ (`BASE_ADDR` + 4·i). Address A(i) = `BASE_ADDR` + 4·i, computed mod 2^32.
- Phases:
  - P1: i = 0..N-1 ascending, write D(i).
  - P2: i ascending, read A(i) and compare with D(i), then write ~D(i) to the same address.
  - P3: i = N-1..0 descending, read A(i) and compare with ~D(i).
- FSM states: IDLE, REQ, RESP, DONE. The phase register and index counter select the access.
- IDLE: `start` moves to REQ with phase P1 and i = 0. On that edge `err_count`, `bus_err`, `first_err_*`, `pass` and `done` are cleared.
- REQ: `o_cyc`=1. `o_adr`, `o_we`, `o_dat` and `o_be` stay stable until the cycle with `i_gnt`=1, then the FSM moves to RESP.
- RESP: `o_cyc`=0. `i_ack` is sampled.
  - `i_ack`=0: set `bus_err` and go to DONE.
  - Read access: if `i_rdt` ≠ expected, increment `err_count`. The first mismatch latches address and data.
  - Then advance to the next access (REQ) or go to DONE after the last P3 read.
- DONE: `done`=1, `busy`=0, `pass` = (`err_count`==0 && !`bus_err`). `start` here begins a new test.
- `start` while busy is ignored.
- Write data on read accesses is don't-care; it is driven 0.

## Timing
- All outputs reset to 0. FSM resets to IDLE with P1 and i = 0.
- Reset mid-test: the next edge zeroes everything, including `o_cyc`. A write granted in the same cycle as `rst` may still land in the responder; this is acceptable.
- Each access takes exactly 2 cycles (REQ, RESP) when `i_gnt` is immediate. Each stalled REQ cycle adds 1 cycle.
- Cycle numbering: `start` is sampled at edge 0. The first `o_cyc` is in cycle 1, and `done` rises in cycle 8N+1+S, where S is the total number of gnt-stall cycles.
- The response is expected only in the cycle immediately after grant. `i_ack` is ignored in all other states, because the responder's ack is sticky.
- Index wrap: the last P3 access is i = 0. The P3 decrement must not underflow into a further access.

## Structure
- Package `dbus_march_pkg`: state enum, phase enum (P1, P2W, P2R, P3), `expected_data(i, inv)` function, `BE_ALL`=4'hF.
- No sub-module; a single always block with counter, FSM and result registers is sufficient.

## Test plan
- Ideal responder (gnt=cyc, ack next cycle), N=4, defaults -> `done` in cycle 33; `pass`=1, `err_count`=0. Write sequence: 0x100 gets 0xA5A5A4A5, 0x104 gets 0xA5A5A4A1, and so on. P3 addresses run 0x10C, 0x108, 0x104, 0x100.
- Responder forces `i_rdt`[0]=0 at 0x108 -> `err_count`=1, `first_err_addr`=0x108, `first_err_data`=0xA5A5A4AC, `pass`=0. The P3 read of ~D = 0x5A5A5B52 matches.
- gnt held low 3 cycles on every request, N=4 -> `done` in cycle 33+48=81. `o_adr`, `o_we` and `o_dat` are unchanged during stalls.
- ack=0 in the RESP of the 2nd access -> `bus_err`=1, `done`=1, `pass`=0, `o_cyc`=0 from that point.
- `rst` pulsed during P2 -> all outputs 0 next cycle. A new `start` begins with a write at 0x100.
- `start` pulsed while busy -> no effect; the total cycle count is unchanged.
